zero_one_hot_gen: RTL
=====================

Name: zero_one_hot_gen

Overview:
Sequential stimulus generator that drives a WIDTH-bit vector which is always zero-one-hot (all-zero or exactly one bit set). It is the driving end of a zero-one-hot checker's test_expr input. It walks a single set bit across positions with programmable hold time, optional zero gaps and direction, under a start/busy/done handshake. Used in OVL checker benches in place of hand-written data sequences.

Parameters:
WIDTH, 4, width of the generated vector (2..32)
HOLD_W, 4, width of the hold-count input
STEP_W, 8, width of the step-count input

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  synchronous active-low reset, sampled on posedge clk
start  input  1  launch request; honoured only in IDLE
hold_cycles  input  HOLD_W  each pattern is held for hold_cycles+1 cycles
num_steps  input  STEP_W  number of one-hot patterns to emit; 0 = immediate done
dir_down  input  1  0 = walk LSB->MSB, 1 = walk MSB->LSB
gap_en  input  1  1 = insert one all-zero cycle between consecutive patterns
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle pulse when the sequence completes
data  output  WIDTH  registered zero-one-hot vector

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, data=0, busy=0, done=0, all counters 0. Reset mid-sequence aborts immediately; no done pulse.
- FSM states: IDLE, HOLD, GAP, FINISH.
- IDLE: data=0. On start=1, latch hold_cycles, num_steps, dir_down, gap_en. If num_steps=0, go to FINISH. Otherwise go to HOLD with data=1 (dir_down=0) or data=1<<(WIDTH-1) (dir_down=1). Latency: start at edge N -> data/busy valid after edge N.
- HOLD: hold counter counts 0..hold_latched. At terminal count, decrement the remaining-step count. If no steps remain, go to FINISH. Else, with gap_en, go to GAP (data=0). Without gap_en, rotate data by one position in the latched direction and stay in HOLD.
- Rotation wraps: MSB->bit0 walking up, bit0->MSB walking down. Steps beyond WIDTH continue wrapping.
- GAP: exactly one cycle with data=0. Then return to HOLD with the rotated pattern, computed from a stored position register.
- FINISH: one cycle. done=1, busy=0, data=0. Then go to IDLE.
- busy is high in HOLD and GAP and low in IDLE and FINISH.
- start outside IDLE is ignored. Input changes after latching have no effect.
- Invariant: $countones(data)<=1 on every cycle. This holds unconditionally when ERR_INJECT_EN is undefined.
- hold counter width is HOLD_W. The maximum hold is 2^HOLD_W cycles and the counter does not overflow.

Optional Feature:
Macro ZERO_ONE_HOT_GEN_ERR_INJECT_EN.
- Defined: adds input err_inject (1 bit). While in HOLD, err_inject=1 ORs the bit adjacent to the current set bit (wrapping) into data for that cycle only. This yields a two-hot vector so the checker's firing path can be exercised. Sequencing and counters are unaffected. err_inject is ignored outside HOLD.
- Undefined: port absent and data is always zero-one-hot.

Decomposition:
- Shared package zero_one_hot_gen_pkg: state enum (IDLE, HOLD, GAP, FINISH) and a rotate_onehot(vec, dir) function.
- One sub-module is natural: zero_one_hot_rot, a combinational WIDTH-parameterised rotate-by-one, instantiated once for next-pattern computation.

Test Plan:
1. WIDTH=4, hold=2, steps=4, up, no gap -> data 0001,0010,0100,1000, each held 3 cycles. done pulses 1 cycle after the last hold. busy high for 12 cycles.
2. steps=6, hold=0, dir_down=1, gap_en=1 -> 1000,0000,0100,0000,0010,0000,0001,0000,1000,0000,0100, then done. Covers wrap.
3. start with num_steps=0 -> next cycle done=1, busy stays 0, data stays 0000.
4. Reset asserted after 3rd pattern -> next edge data=0000, busy=0, no done pulse. A new start is accepted immediately afterwards.
5. Second start while busy, with different inputs -> ignored; sequence completes with the originally latched values.
6. Run an ovl_zero_one_hot checker (width 4) on data across scenarios 1-5 -> zero firings. With ZERO_ONE_HOT_GEN_ERR_INJECT_EN and err_inject pulsed at data=0010 -> data=0110 for one cycle and exactly one checker firing.

Source files
------------

// File: rtl/zero_one_hot_gen_pkg.sv
// ============================================================================
// Module   : zero_one_hot_gen_pkg
// Purpose  : Shared state encoding and one-hot rotate helper for the
//            zero-one-hot stimulus generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package zero_one_hot_gen_pkg;

  // Widest vector the generator supports.
  localparam int MAX_WIDTH = 32;

  // Generator FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_HOLD   = 2'd1;
  localparam state_t ST_GAP    = 2'd2;
  localparam state_t ST_FINISH = 2'd3;

  // Rotate the low 'width' bits of vec by one place; dir=0 walks toward the
  // MSB (MSB wraps to bit 0), dir=1 walks toward the LSB (bit 0 wraps to MSB).
  function automatic logic [MAX_WIDTH-1:0] rotate_onehot(
    input logic [MAX_WIDTH-1:0] vec,
    input logic                 dir,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    mask = (width >= MAX_WIDTH) ? '1
                                : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    if (!dir) begin
      rotate_onehot = ((vec << 1) | (vec >> (width - 1))) & mask;
    end else begin
      rotate_onehot = ((vec >> 1) | (vec << (width - 1))) & mask;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/zero_one_hot_rot.sv
// ============================================================================
// Module   : zero_one_hot_rot
// Purpose  : Combinational rotate-by-one of a WIDTH-bit vector, with wrap,
//            in either direction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_one_hot_rot
  import zero_one_hot_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             dir,
  output logic [WIDTH-1:0] rot
);

  // Each output bit picks its lower neighbour when walking up and its upper
  // neighbour when walking down; the ends wrap around.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int UP_SRC = (i == 0) ? (WIDTH - 1) : (i - 1);
    localparam int DN_SRC = (i == WIDTH - 1) ? 0 : (i + 1);
    assign rot[i] = dir ? vec[DN_SRC] : vec[UP_SRC];
  end

endmodule

`default_nettype wire

// File: rtl/zero_one_hot_gen.sv
// ============================================================================
// Module   : zero_one_hot_gen
// Purpose  : Sequential generator of a zero-one-hot WIDTH-bit vector. Walks a
//            single set bit with programmable hold time, direction and
//            optional all-zero gaps, under a start/busy/done handshake.
//            Optional macro ZERO_ONE_HOT_GEN_ERR_INJECT_EN adds an err_inject
//            input that forces a two-hot vector for one cycle in HOLD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zero_one_hot_gen
  import zero_one_hot_gen_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int HOLD_W = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              dir_down,
  input  logic              gap_en,
`ifdef ZERO_ONE_HOT_GEN_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  data
);

  localparam logic [WIDTH-1:0] LSB_PAT = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_PAT = LSB_PAT << (WIDTH - 1);

  state_t              state;
  logic [WIDTH-1:0]    pat;        // current walking position, kept across gaps
  logic [WIDTH-1:0]    data_q;
  logic [HOLD_W-1:0]   hold_lat;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [STEP_W-1:0]   steps_left;
  logic                dir_lat;
  logic                gap_lat;
  logic                busy_q;
  logic                done_q;
  logic [WIDTH-1:0]    rot_pat;
  logic [WIDTH-1:0]    start_pat;

  // Next position in the latched walking direction.
  zero_one_hot_rot #(
    .WIDTH (WIDTH)
  ) u_rot (
    .vec (pat),
    .dir (dir_lat),
    .rot (rot_pat)
  );

  assign start_pat = dir_down ? MSB_PAT : LSB_PAT;

  // Sequencer: latches the request, holds each pattern, inserts gaps and
  // signals completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pat        <= '0;
      data_q     <= '0;
      hold_lat   <= '0;
      hold_cnt   <= '0;
      steps_left <= '0;
      dir_lat    <= 1'b0;
      gap_lat    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          data_q <= '0;
          busy_q <= 1'b0;
          if (start) begin
            hold_lat   <= hold_cycles;
            steps_left <= num_steps;
            dir_lat    <= dir_down;
            gap_lat    <= gap_en;
            hold_cnt   <= '0;
            if (num_steps == '0) begin
              state  <= ST_FINISH;
              done_q <= 1'b1;
            end else begin
              state  <= ST_HOLD;
              busy_q <= 1'b1;
              pat    <= start_pat;
              data_q <= start_pat;
            end
          end
        end

        ST_HOLD: begin
          if (hold_cnt == hold_lat) begin
            hold_cnt   <= '0;
            steps_left <= steps_left - STEP_W'(1);
            if (steps_left == STEP_W'(1)) begin
              state  <= ST_FINISH;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              data_q <= '0;
            end else begin
              pat <= rot_pat;
              if (gap_lat) begin
                state  <= ST_GAP;
                data_q <= '0;
              end else begin
                data_q <= rot_pat;
              end
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_GAP: begin
          // pat was advanced on the way into the gap.
          state  <= ST_HOLD;
          data_q <= pat;
        end

        ST_FINISH: begin
          state  <= ST_IDLE;
          data_q <= '0;
          busy_q <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

`ifdef ZERO_ONE_HOT_GEN_ERR_INJECT_EN
  // In HOLD data equals pat, so rot_pat is the neighbouring bit; OR-ing it in
  // gives a two-hot vector for exactly the cycles err_inject is high.
  assign data = data_q | ((err_inject && (state == ST_HOLD)) ? rot_pat : '0);
`else
  assign data = data_q;
`endif

endmodule

`default_nettype wire
